floor_request_manager: RTL

- Upstream stage of the elevator controller: turns raw, bouncy, asynchronous hall/cab button inputs into the latched per-floor request vector consumed as floors_triggered.
- Each button is synchronized, debounced and edge-detected, then latched into a pending register.
- A pending request is retired when the car departs the whole floor where it was served; departure is detected from the controller's floor output.

---
 rtl/floor_request_manager.sv | 102 ++++++++++
 1 files changed

// File: rtl/floor_request_manager.sv
// Floor request manager: synchronizes, debounces and edge-detects raw
// hall/cab buttons, latches presses into a pending vector, and retires a
// pending floor when the car departs that whole floor.
module floor_request_manager #(
  parameter int NUM_FLOORS      = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_FLOORS-1:0] buttons,
  input  logic [3:0]            floor,
  output logic [NUM_FLOORS-1:0] floors_triggered,
  output logic                  new_request,
  output logic [2:0]            pending_count
);

  // Counter value on which the next differing sample completes the run.
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]           NF4     = 4'(NUM_FLOORS);

  logic [NUM_FLOORS-1:0]                sync1_q, sync2_q;
  logic [NUM_FLOORS-1:0]                stable_q, stable_d, stable_prev_q;
  logic [NUM_FLOORS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]                           floor_q;
  logic [NUM_FLOORS-1:0]                ft_q, ft_d;
  logic                                 new_q, new_d;
  logic [2:0]                           cnt_pend_q, cnt_pend_d;
  logic [NUM_FLOORS-1:0]                set, clr;
  logic                                 depart;

  // Per-lane debounce: a level differing from the accepted one must hold
  // DEBOUNCE_CYCLES synchronized cycles in a row before it is accepted.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      if (sync2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == DB_LAST) begin
        cnt_d[k]    = '0;
        stable_d[k] = ~stable_q[k];
      end else begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  // Only presses count; releases generate no event.
  assign set = stable_q & ~stable_prev_q;

  // Leaving a whole, in-range floor retires that floor's request.
  assign depart = en && (floor != floor_q) && !floor_q[0] &&
                  ({1'b0, floor_q[3:1]} < NF4);

  // One-hot clear for the floor just departed.
  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_FLOORS; k++)
      clr[k] = depart && (floor_q[3:1] == 3'(k));
  end

  // Pending update (set beats clear) plus registered side outputs.
  always_comb begin
    ft_d       = (ft_q & ~clr) | set;
    new_d      = |(set & ~ft_q);
    cnt_pend_d = '0;
    for (int k = 0; k < NUM_FLOORS; k++)
      cnt_pend_d = cnt_pend_d + 3'(ft_d[k]);
  end

  // State registers; async reset discards every pending request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      cnt_q         <= '0;
      stable_q      <= '0;
      stable_prev_q <= '0;
      floor_q       <= '0;
      ft_q          <= '0;
      new_q         <= 1'b0;
      cnt_pend_q    <= '0;
    end else begin
      sync1_q       <= buttons;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      floor_q       <= floor;
      ft_q          <= ft_d;
      new_q         <= new_d;
      cnt_pend_q    <= cnt_pend_d;
    end
  end

  assign floors_triggered = ft_q;
  assign new_request      = new_q;
  assign pending_count    = cnt_pend_q;

endmodule
